mem_access_unit: RTL and testbench

//  Memory-stage load/store unit between the pipeline's M stage and the data bus. Converts

---
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between mem_access_unit (master) and the memory side (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: byte-lane bus transaction, ack wait with watchdog, load extension.
// Optional macro MEM_ALIGN_EXC_EN: trap misaligned accesses via adelM/adesM instead of aligning.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [1:0]  memsizeM,
  input  logic        memsignM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        buserrM,
  output logic        adelM,
  output logic        adesM,
  mem_access_unit_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [31:0]      rdata_q,  rdata_d;
  logic             buserr_q, buserr_d;
  logic             req_q,    req_d;
  logic             we_q,     we_d;
  logic [31:0]      addr_q,   addr_d;
  logic [3:0]       be_q,     be_d;
  logic [31:0]      wdata_q,  wdata_d;
  logic [1:0]       off_q,    off_d;
  logic [1:0]       size_q,   size_d;
  logic             sign_q,   sign_d;

  logic        is_half_c, is_word_c, accept_c;
  logic [1:0]  off_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, lane_c, load_c;

  assign is_half_c = (memsizeM == 2'b01);
  assign is_word_c = memsizeM[1];

  // Offending low address bits are dropped so every access is naturally aligned.
  assign off_c = is_word_c ? 2'b00 : (is_half_c ? {aluoutM[1], 1'b0} : aluoutM[1:0]);

`ifdef MEM_ALIGN_EXC_EN
  logic misalign_c;
  assign misalign_c = (is_half_c & aluoutM[0]) | (is_word_c & (|aluoutM[1:0]));
  assign accept_c   = memenM & ~misalign_c;
  assign adelM      = (state_q == IDLE) & memenM & misalign_c & ~memwriteM;
  assign adesM      = (state_q == IDLE) & memenM & misalign_c &  memwriteM;
`else
  assign accept_c   = memenM;
  assign adelM      = 1'b0;
  assign adesM      = 1'b0;
`endif

  // Store lane steering.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = writedataM;
    if (!is_word_c) begin
      if (is_half_c) begin
        be_c    = off_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{writedataM[15:0]}};
      end else begin
        be_c    = 4'b0001 << off_c;
        wdata_c = {4{writedataM[7:0]}};
      end
    end
  end

  // Load lane extraction and extension from the captured access attributes.
  assign lane_c = bus.bus_rdata >> {off_q, 3'b000};
  always_comb begin
    load_c = lane_c;
    if (!size_q[1]) begin
      if (size_q == 2'b01) load_c = {{16{sign_q & lane_c[15]}}, lane_c[15:0]};
      else                 load_c = {{24{sign_q & lane_c[7]}},  lane_c[7:0]};
    end
  end

  // Next-state and combinational stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    buserr_d = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    off_d    = off_q;
    size_d   = size_q;
    sign_d   = sign_q;
    stallM   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          stallM  = 1'b1;
          state_d = REQ;
          cnt_d   = '0;
          we_d    = memwriteM;
          addr_d  = {aluoutM[31:2], 2'b00};
          be_d    = be_c;
          wdata_d = wdata_c;
          off_d   = off_c;
          size_d  = memsizeM;
          sign_d  = memsignM;
        end
      end
      REQ: begin
        stallM = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (bus.bus_ack) begin
          state_d = DONE;
          if (!we_q) rdata_d = load_c;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d  = DONE;
          buserr_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      size_q   <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
    end
  end

  assign readdataM     = rdata_q;
  assign buserrM       = buserr_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4) with an expected-readdata scoreboard queue.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, memsignM;
  logic [1:0]  memsizeM;
  logic [31:0] aluoutM, writedataM, readdataM;
  logic        stallM, buserrM, adelM, adesM;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memwriteM  (memwriteM),
    .memsizeM   (memsizeM),
    .memsignM   (memsignM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .buserrM    (buserrM),
    .adelM      (adelM),
    .adesM      (adesM),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned fails   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access; ack is returned ack_dly cycles into REQ.
  task automatic do_access(input string tag, input logic we, input logic [1:0] sz,
                           input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int ack_dly,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    int stall_cyc;
    logic [31:0] e;
    @(negedge clk);
    memenM = 1'b1; memwriteM = we; memsizeM = sz; memsignM = sg;
    aluoutM = addr; writedataM = wd;
    exp_q.push_back(exp_rd);
    #1 check({tag, " stall_idle"}, 32'(stallM), 32'd1);
    stall_cyc = 1;
    @(negedge clk);
    memenM = 1'b0;
    check({tag, " bus_req"},   32'(bus_if.bus_req), 32'd1);
    check({tag, " bus_we"},    32'(bus_if.bus_we),  32'(we));
    check({tag, " bus_addr"},  bus_if.bus_addr,     exp_addr);
    check({tag, " bus_be"},    32'(bus_if.bus_be),  32'(exp_be));
    check({tag, " bus_wdata"}, bus_if.bus_wdata,    exp_wd);
    for (int k = 0; k < 8; k++) begin
      if (!stallM) break;
      stall_cyc++;
      if (k == ack_dly) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
      end
      @(negedge clk);
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 32'h0;
    end
    check({tag, " stall_cycles"}, 32'(stall_cyc), 32'(ack_dly + 2));
    check({tag, " req_done"},     32'(bus_if.bus_req), 32'd0);
    check({tag, " buserr"},       32'(buserrM), 32'd0);
    e = exp_q.pop_front();
    check({tag, " readdata"}, readdataM, e);
    last_rd = e;
  endtask

  initial begin
    int req_cyc;
    rst = 1'b1; memenM = 1'b0; memwriteM = 1'b0; memsizeM = 2'b00; memsignM = 1'b0;
    aluoutM = '0; writedataM = '0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    check("rst readdata", readdataM, 32'h0);
    check("rst stall",    32'(stallM), 32'd0);
    check("rst bus_req",  32'(bus_if.bus_req), 32'd0);
    check("rst bus_be",   32'(bus_if.bus_be), 32'd0);
    check("rst buserr",   32'(buserrM), 32'd0);
    rst = 1'b0;

    do_access("LW",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0,
              32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    do_access("LB",   1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 1,
              32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    do_access("LBU",  1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0,
              32'h100, 4'b1000, 32'h0, 32'h00000080);
    do_access("SH",   1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 2,
              32'h200, 4'b1100, 32'hABCDABCD, 32'h00000080);
    do_access("SB",   1'b1, 2'b00, 1'b0, 32'h101, 32'h1111115A, 32'h0, 0,
              32'h100, 4'b0010, 32'h5A5A5A5A, 32'h00000080);
    do_access("LH",   1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80017FFF, 3,
              32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
    do_access("LHU",  1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h8001F00D, 1,
              32'h100, 4'b0011, 32'h0, 32'h0000F00D);
    do_access("SW",   1'b1, 2'b10, 1'b0, 32'h30C, 32'hCAFEF00D, 32'h0, 0,
              32'h30C, 4'b1111, 32'hCAFEF00D, 32'h0000F00D);
    do_access("LW11", 1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 32'h01234567, 0,
              32'h400, 4'b1111, 32'h0, 32'h01234567);

`ifdef MEM_ALIGN_EXC_EN
    @(negedge clk);
    memenM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; aluoutM = 32'h101;
    #1 check("misLW adel",  32'(adelM), 32'd1);
    check("misLW stall", 32'(stallM), 32'd0);
    @(negedge clk);
    memenM = 1'b0;
    check("misLW bus_req",  32'(bus_if.bus_req), 32'd0);
    check("misLW readdata", readdataM, last_rd);
    @(negedge clk);
    memenM = 1'b1; memwriteM = 1'b1; memsizeM = 2'b01; aluoutM = 32'h203;
    #1 check("misSH ades", 32'(adesM), 32'd1);
    check("misSH adel", 32'(adelM), 32'd0);
    @(negedge clk);
    memenM = 1'b0;
    check("misSH bus_req", 32'(bus_if.bus_req), 32'd0);
`else
    do_access("misLW", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h11223344, 0,
              32'h100, 4'b1111, 32'h0, 32'h11223344);
    do_access("misLH", 1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 32'hBEEF0000, 1,
              32'h100, 4'b1100, 32'h0, 32'hFFFFBEEF);
    check("noexc adel", 32'(adelM), 32'd0);
`endif

    // Watchdog: no ack ever.
    @(negedge clk);
    memenM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; memsignM = 1'b0; aluoutM = 32'h500;
    exp_q.push_back(last_rd);
    @(negedge clk);
    memenM = 1'b0;
    req_cyc = 0;
    for (int k = 0; k < 10; k++) begin
      if (!bus_if.bus_req) break;
      req_cyc++;
      @(negedge clk);
    end
    check("wdog req_cycles", 32'(req_cyc), 32'd4);
    check("wdog buserr",     32'(buserrM), 32'd1);
    check("wdog stall",      32'(stallM), 32'd0);
    check("wdog readdata",   readdataM, exp_q.pop_front());
    @(negedge clk);
    check("wdog buserr_pulse", 32'(buserrM), 32'd0);

    // Reset in the middle of REQ, then a stale ack.
    @(negedge clk);
    memenM = 1'b1; memwriteM = 1'b0; memsizeM = 2'b10; aluoutM = 32'h600;
    @(negedge clk);
    memenM = 1'b0;
    check("rstmid req_before", 32'(bus_if.bus_req), 32'd1);
    rst = 1'b1;
    #1 check("rstmid bus_req", 32'(bus_if.bus_req), 32'd0);
    check("rstmid stall", 32'(stallM), 32'd0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h55555555;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check("lateack readdata", readdataM, 32'h0);
    check("lateack bus_req",  32'(bus_if.bus_req), 32'd0);
    check("lateack stall",    32'(stallM), 32'd0);

    do_access("postrst", 1'b0, 2'b00, 1'b0, 32'h700, 32'h0, 32'h000000A5, 0,
              32'h700, 4'b0001, 32'h0, 32'h000000A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
